// File: rtl/clcd_write_arb_if.sv
// Client and LCD pin bundle for clcd_write_arb.
// master = client/pin side, slave = the arbiter itself.
interface clcd_write_arb_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       ack1;
  logic       busy;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (
    output req0, rs0, data0, req1, rs1, data1,
    input  ack0, ack1, busy, LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );

  modport slave (
    input  req0, rs0, data0, req1, rs1, data1,
    output ack0, ack1, busy, LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );
endinterface

// File: rtl/clcd_write_arb.sv
// 16x2 LCD bus owner: runs power-up init, then arbitrates single-byte writes from two clients.
// Define CLCD_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties) instead of round-robin.
module clcd_write_arb #(
  parameter int INIT_DLY = 70,
  parameter int CMD_CYC  = 30,
  parameter int CLR_CYC  = 200,
  parameter int E_HI     = 4
) (
  input  logic              clk,
  input  logic              rst,
  clcd_write_arb_if.slave   bus
);

  localparam int MAX_A = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
  localparam int MAX_C = (INIT_DLY > MAX_A) ? INIT_DLY : MAX_A;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {INIT_WAIT, INIT_CMD, IDLE, WRITE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             e_q, e_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
`ifndef CLCD_ARB_FIXED_PRIO_EN
  logic             rr_q, rr_d;   // client granted last (1 = client 1)
`endif

  logic win1;
  logic is_clr;
  logic slot_last;
  logic in_slot_d;

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    init_rom = 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h06;
      default: init_rom = 8'h01;
    endcase
  endfunction

  // Clear and home need the long slot, whether issued by init or a client.
  assign is_clr    = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
  assign slot_last = is_clr ? (cnt_q == CNT_W'(CLR_CYC - 1))
                            : (cnt_q == CNT_W'(CMD_CYC - 1));

`ifdef CLCD_ARB_FIXED_PRIO_EN
  assign win1 = bus.req1 && !bus.req0;
`else
  assign win1 = bus.req1 && (!bus.req0 || !rr_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifndef CLCD_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      INIT_WAIT: begin
        if (cnt_q == CNT_W'(INIT_DLY - 1)) begin
          state_d = INIT_CMD;
          cnt_d   = '0;
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          data_d  = init_rom(2'd0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      INIT_CMD: begin
        if (slot_last) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = init_rom(idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = WRITE;
          cnt_d   = '0;
          if (win1) begin
            rs_d   = bus.rs1;
            data_d = bus.data1;
            ack1_d = 1'b1;
`ifndef CLCD_ARB_FIXED_PRIO_EN
            rr_d   = 1'b1;
`endif
          end else begin
            rs_d   = bus.rs0;
            data_d = bus.data0;
            ack0_d = 1'b1;
`ifndef CLCD_ARB_FIXED_PRIO_EN
            rr_d   = 1'b0;
`endif
          end
        end
      end
      WRITE: begin
        if (slot_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // Pin outputs are registered from the next state so they are glitch-free.
    in_slot_d = (state_d == INIT_CMD) || (state_d == WRITE);
    e_d       = in_slot_d && (cnt_d != '0) && (cnt_d <= CNT_W'(E_HI));
    rw_d      = !in_slot_d;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_WAIT;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      e_q     <= 1'b0;
      rw_q    <= 1'b1;
      busy_q  <= 1'b1;
`ifndef CLCD_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      e_q     <= e_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
`ifndef CLCD_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = busy_q;
  assign bus.LCD_E    = e_q;
  assign bus.LCD_RS   = rs_q;
  assign bus.LCD_RW   = rw_q;
  assign bus.LCD_DATA = data_q;

endmodule

// File: tb/tb_clcd_write_arb.sv
// Scoreboard bench for clcd_write_arb: expected slot bytes are queued as stimulus is driven
// and popped on every LCD_E rise; per-scenario tasks check timing inline.
module tb_clcd_write_arb;
  localparam int E_HI_TB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clcd_write_arb_if bus();

  clcd_write_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rel_cyc  = 0;

  always @(posedge clk) begin
    if (rst) rel_cyc <= 0;
    else     rel_cyc <= rel_cyc + 1;
  end

  logic [8:0] exp_q[$];
  int   first_rise = -1;
  int   last_rise  = -1;

  // Slot monitor: each E rise is one transaction.
  initial begin
    int         hi_cnt;
    logic       e_prev;
    logic [8:0] e_exp;
    hi_cnt = 0;
    e_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        first_rise = -1;
        hi_cnt     = 0;
        e_prev     = 1'b0;
      end else begin
        if (bus.LCD_E && !e_prev) begin
          last_rise = rel_cyc;
          if (first_rise < 0) first_rise = rel_cyc;
          $display("slot cyc=%0d rs=%0d data=%02h rw=%0d", rel_cyc, bus.LCD_RS, bus.LCD_DATA, bus.LCD_RW);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL slot_unexpected got rs=%0d data=%02h required no slot", bus.LCD_RS, bus.LCD_DATA);
          end else begin
            e_exp = exp_q.pop_front();
            if ({bus.LCD_RS, bus.LCD_DATA} !== e_exp) begin
              failures++;
              $display("FAIL slot_byte got rs/data=%03h required %03h", {bus.LCD_RS, bus.LCD_DATA}, e_exp);
            end
          end
          checks++;
          if (bus.LCD_RW !== 1'b0) begin
            failures++;
            $display("FAIL slot_rw got %0b required 0", bus.LCD_RW);
          end
        end
        if (bus.LCD_E) begin
          hi_cnt++;
        end else if (e_prev) begin
          checks++;
          if (hi_cnt != E_HI_TB) begin
            failures++;
            $display("FAIL e_width got %0d required %0d", hi_cnt, E_HI_TB);
          end
          hi_cnt = 0;
        end
        e_prev = bus.LCD_E;
      end
    end
  end

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int bound, output logic a0, output logic a1, output bit ok);
    ok = 1'b0;
    a0 = 1'b0;
    a1 = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        a0 = bus.ack0;
        a1 = bus.ack1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.LCD_E, bus.LCD_RW, bus.LCD_RS} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_ctrl got busy/E/RW/RS=%04b required 1010", {bus.busy, bus.LCD_E, bus.LCD_RW, bus.LCD_RS});
    end
    checks++;
    if (bus.LCD_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got %02h required 00", bus.LCD_DATA);
    end
    checks++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ack got %02b required 00", {bus.ack0, bus.ack1});
    end
  endtask

  task automatic test_init();
    bit ok;
    push_init();
    rst = 1'b0;
    wait_idle(1000, ok);
    checks++;
    if (!ok || rel_cyc != 360) begin
      failures++;
      $display("FAIL init_idle_cycle got ok=%0b cyc=%0d required cyc=360", ok, rel_cyc);
    end
    checks++;
    if (first_rise != 71) begin
      failures++;
      $display("FAIL init_first_e got %0d required 71", first_rise);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL init_pending got %0d slots left required 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int   exp_win[3];
    logic a0, a1;
    bit   ok;
`ifdef CLCD_ARB_FIXED_PRIO_EN
    exp_win = '{0, 0, 0};
`else
    exp_win = '{0, 1, 0};
`endif
    bus.rs0 = 1'b1; bus.data0 = 8'h31; bus.req0 = 1'b1;
    bus.rs1 = 1'b1; bus.data1 = 8'h32; bus.req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, (exp_win[i] == 1) ? 8'h32 : 8'h31});
      wait_ack(100, a0, a1, ok);
      checks++;
      if (!ok || a0 !== (exp_win[i] == 0) || a1 !== (exp_win[i] == 1)) begin
        failures++;
        $display("FAIL rr_grant%0d got ok=%0b ack0=%0b ack1=%0b required client %0d", i, ok, a0, a1, exp_win[i]);
      end
      if (a1) bus.req1 = 1'b0;
      else    bus.req0 = 1'b0;
      @(negedge clk);
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rr_drain got ok=%0b pending=%0d required idle with 0 pending", ok, exp_q.size());
    end
  endtask

  task automatic test_single_write();
    logic [11:0] got, want;
    logic a0, a1;
    bit   ok;
    bus.rs0 = 1'b1; bus.data0 = 8'h41; bus.req0 = 1'b1;
    exp_q.push_back({1'b1, 8'h41});
    wait_ack(10, a0, a1, ok);
    checks++;
    if (!ok || a0 !== 1'b1 || a1 !== 1'b0) begin
      failures++;
      $display("FAIL single_ack got ok=%0b ack0=%0b ack1=%0b required ack0 only", ok, a0, a1);
    end
    bus.req0 = 1'b0;
    // k = slot cycle (0 on the ack cycle); k = 30 is back in IDLE.
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) @(negedge clk);
      want = {(k >= 1 && k <= E_HI_TB) ? 1'b1 : 1'b0, (k < 30) ? 1'b0 : 1'b1,
              (k < 30) ? 1'b1 : 1'b0, 1'b1, 8'h41};
      got  = {bus.LCD_E, bus.LCD_RW, bus.busy, bus.LCD_RS, bus.LCD_DATA};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL single_slot_k%0d got E/RW/busy/RS/data=%03h required %03h", k, got, want);
      end
      if (k == 1) begin
        checks++;
        if (bus.ack0 !== 1'b0) begin
          failures++;
          $display("FAIL single_ack_width got ack0=%0b required 0", bus.ack0);
        end
      end
    end
  endtask

  task automatic test_clear_slot();
    int   a_cyc, b_cyc;
    logic a0, a1;
    bit   ok;
    bus.rs1 = 1'b0; bus.data1 = 8'h01; bus.req1 = 1'b1;
    exp_q.push_back({1'b0, 8'h01});
    wait_ack(10, a0, a1, ok);
    a_cyc = rel_cyc;
    checks++;
    if (!ok || a1 !== 1'b1 || a0 !== 1'b0) begin
      failures++;
      $display("FAIL clr_ack got ok=%0b ack0=%0b ack1=%0b required ack1 only", ok, a0, a1);
    end
    bus.req1 = 1'b0;
    bus.rs0 = 1'b1; bus.data0 = 8'h42; bus.req0 = 1'b1;
    exp_q.push_back({1'b1, 8'h42});
    wait_ack(400, a0, a1, ok);
    b_cyc = rel_cyc;
    bus.req0 = 1'b0;
    checks++;
    if (!ok || a0 !== 1'b1 || (b_cyc - a_cyc) != 201) begin
      failures++;
      $display("FAIL clr_len got ok=%0b ack0=%0b gap=%0d required ack0 gap=201", ok, a0, b_cyc - a_cyc);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok || (last_rise - a_cyc) < 201 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL clr_next_e got ok=%0b rise_gap=%0d pending=%0d required gap>=201 pending=0",
               ok, last_rise - a_cyc, exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
    logic a0, a1;
    bit   ok;
    bus.rs0 = 1'b1; bus.data0 = 8'h77; bus.req0 = 1'b1;
    exp_q.push_back({1'b1, 8'h77});
    wait_ack(10, a0, a1, ok);
    checks++;
    if (!ok || a0 !== 1'b1) begin
      failures++;
      $display("FAIL abort_ack got ok=%0b ack0=%0b required 1", ok, a0);
    end
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.LCD_E !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_e got %0b required 1", bus.LCD_E);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.LCD_E, bus.busy, bus.LCD_RW, bus.ack0, bus.ack1} !== 5'b01100 || bus.LCD_DATA !== 8'h00) begin
      failures++;
      $display("FAIL abort_async got E/busy/RW/ack0/ack1=%05b data=%02h required 01100 data=00",
               {bus.LCD_E, bus.busy, bus.LCD_RW, bus.ack0, bus.ack1}, bus.LCD_DATA);
    end
    repeat (3) @(negedge clk);
    push_init();
    rst = 1'b0;
    wait_idle(1000, ok);
    checks++;
    if (!ok || rel_cyc != 360 || first_rise != 71 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_reinit got ok=%0b idle_cyc=%0d first_e=%0d pending=%0d required 360/71/0",
               ok, rel_cyc, first_rise, exp_q.size());
    end
  endtask

  task automatic test_req_during_init();
    logic a0, a1;
    bit   ok;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push_init();
    exp_q.push_back({1'b1, 8'h55});
    bus.rs0 = 1'b1; bus.data0 = 8'h55; bus.req0 = 1'b1;
    rst = 1'b0;
    wait_ack(1000, a0, a1, ok);
    checks++;
    if (!ok || a0 !== 1'b1 || rel_cyc != 361) begin
      failures++;
      $display("FAIL init_req_ack got ok=%0b ack0=%0b cyc=%0d required ack0 at 361", ok, a0, rel_cyc);
    end
    bus.req0 = 1'b0;
    wait_idle(100, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL init_req_drain got ok=%0b pending=%0d required idle with 0 pending", ok, exp_q.size());
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.rs0 = 1'b0; bus.data0 = 8'h00;
    bus.req1 = 1'b0; bus.rs1 = 1'b0; bus.data1 = 8'h00;
    test_reset();
    test_init();
    test_round_robin();
    test_single_write();
    test_clear_slot();
    test_reset_abort();
    test_req_during_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clcd_write_arb.md
Name: clcd_write_arb

Overview:
- Shared controller for the 16x2 character LCD bus.
- After reset it runs the power-up init sequence itself, then arbitrates single-byte write requests from two clients, e.g. game logic and status/score logic.
- Each granted byte is driven as one timed bus slot with a generated E strobe, replacing free-running clk-as-E.
- Sits between client logic and the LCD_E/LCD_RS/LCD_RW/LCD_DATA pins.

Parameters:
- INIT_DLY, 70, idle cycles after reset before the first init command.
- CMD_CYC, 30, slot length in cycles for a normal command or data write.
- CLR_CYC, 200, slot length for clear (0x01) and home (0x02) commands.
- E_HI, 4, number of cycles LCD_E is high within a slot; requires 1 <= E_HI <= CMD_CYC-2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous reset, active-high.
- req0, input, 1, client 0 write request (level).
- rs0, input, 1, client 0 register select (0=command, 1=data).
- data0, input, 8, client 0 byte.
- ack0, output, 1, client 0 one-cycle accept pulse.
- req1, input, 1, client 1 write request.
- rs1, input, 1, client 1 register select.
- data1, input, 8, client 1 byte.
- ack1, output, 1, client 1 accept pulse.
- busy, output, 1, high whenever the state is not IDLE.
- LCD_E, output, 1, LCD enable strobe.
- LCD_RS, output, 1, LCD register select.
- LCD_RW, output, 1, LCD read/write.
- LCD_DATA, output, 8, LCD data bus.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Every register clears on rst rising, with no clock required.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_DATA=0x00, ack0=ack1=0, busy=1, state=INIT_WAIT, cnt=0, init index=0, round-robin pointer=1 (client 0 wins the first tie).
- INIT_WAIT: cnt counts 0..INIT_DLY-1. On the last count, go to INIT_CMD.
- INIT_CMD: emits four slots in order, all with RS=0: 0x38, 0x0C, 0x06 (CMD_CYC each), then 0x01 (CLR_CYC). After the last slot, go to IDLE. Defaults give the first IDLE cycle 360 cycles after rst deasserts.
- IDLE:
  - busy=0, LCD_E=0, LCD_RW=1. LCD_RS and LCD_DATA hold their last values.
  - With any req high at a clock edge: pick the winner, latch its rs/data, pulse ack for exactly the next cycle, go to WRITE.
- WRITE slot:
  - Length L=CLR_CYC if latched rs=0 and data is 0x01 or 0x02; otherwise L=CMD_CYC.
  - cnt runs 0..L-1.
  - LCD_RW=0, and LCD_RS/LCD_DATA are the latched values for the whole slot.
  - LCD_E=1 exactly when 1 <= cnt <= E_HI.
  - After cnt=L-1, return to IDLE for at least one cycle before the next grant.
  - Init slots use the identical timing rules.
- Arbitration:
  - Round-robin on ties: grant the client that was not granted last.
  - A lone requester always wins.
  - The pointer updates only on a grant.
- Client rule: hold req, rs and data stable until ack is seen, then drop req. Requests arriving while busy wait; none are lost, since req is level-sensitive.
- req during INIT_WAIT/INIT_CMD is ignored until IDLE; no ack is given early.
- rst during a WRITE or INIT slot aborts immediately. E returns to 0 asynchronously, the latched byte is discarded, no ack is issued, and init reruns from INIT_WAIT.
- ack0 and ack1 are never high in the same cycle. Each ack pulse is always followed by exactly one slot.

Optional Feature:
- Macro: CLCD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, client 0 always beats client 1 on a tie; the round-robin pointer is not implemented.
- Undefined: round-robin as above.

Test Plan:
- Reset release, no requests -> LCD_E pulses 4 times with RS=0. DATA on those pulses is 0x38, 0x0C, 0x06, 0x01. First E rise is at cycle 71. busy falls at cycle 360.
- After init, req0 with rs0=1, data0=0x41 -> ack0 high one cycle. Then a 30-cycle slot with RS=1, DATA=0x41, RW=0 and E high for cycles 1-4. Then busy=0.
- req0 and req1 held together with data 0x31/0x32 -> grants alternate 0x31, 0x32, 0x31. With CLCD_ARB_FIXED_PRIO_EN defined, only 0x31 slots occur while req0 stays high.
- req1 with rs1=0, data1=0x01 -> slot lasts 200 cycles. The next queued req0 byte's E rise occurs no earlier than 201 cycles after the clear slot starts.
- Assert rst at cnt=2 of a WRITE slot -> LCD_E=0 immediately, no ack, full init sequence repeats.
- req0 held high during INIT_WAIT -> no ack before the first IDLE cycle; ack0 occurs at cycle 361.
